// File: rtl/stoch_pkg.sv
// Shared types and helpers for the stochastic-computing arithmetic blocks.
// Contains only constant functions and types; no logic of its own.
package stoch_pkg;

    typedef enum logic {
        UNIPOLAR = 1'b0,
        BIPOLAR  = 1'b1
    } coding_e;

    // Ceiling log2. A value n needs clog2(n+1) bits.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Returns a + b clamped to the range of a w-bit signed register (w <= 30).
    function automatic int sat_add(input int a, input int b, input int w);
        longint s;
        longint hi;
        longint lo;
        s  = longint'(a) + longint'(b);
        hi = (longint'(1) <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (s > hi) begin
            return int'(hi);
        end
        if (s < lo) begin
            return int'(lo);
        end
        return int'(s);
    endfunction

endpackage

// File: rtl/stoch_popcnt.sv
// Combinational popcount built as a recursive binary adder tree.
// Zero latency; no flow control.
module stoch_popcnt
    import stoch_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [W-1:0]            vec_i,
    output logic [clog2(W+1)-1:0]   cnt_o
);

    localparam int OW = clog2(W + 1);

    if (W == 1) begin : g_leaf
        assign cnt_o = vec_i;
    end else begin : g_node
        localparam int LO = W / 2;
        localparam int HI = W - LO;
        localparam int LW = clog2(LO + 1);
        localparam int HW = clog2(HI + 1);

        logic [LW-1:0] lo_cnt;
        logic [HW-1:0] hi_cnt;

        stoch_popcnt #(.W(LO)) u_lo (
            .vec_i (vec_i[LO-1:0]),
            .cnt_o (lo_cnt)
        );

        stoch_popcnt #(.W(HI)) u_hi (
            .vec_i (vec_i[W-1:LO]),
            .cnt_o (hi_cnt)
        );

        assign cnt_o = OW'(lo_cnt) + OW'(hi_cnt);
    end

endmodule

// File: rtl/stoch_nsadd_par.sv
// Non-scaled stochastic adder: emits a 1 whenever emitted ones lag the summed input target.
// out is combinational from the registered error (input reaches out one cycle later);
// en=0 stalls the stream: state holds and out is forced low.
module stoch_nsadd_par #(
    parameter int NUM_IN  = 16,
    parameter int BIPOLAR = 0,
    parameter int ERR_W   = 14,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic [NUM_IN-1:0] mask,
    input  logic [NUM_IN-1:0] in,
    output logic              out,
    output logic              sat,
    output logic [CNT_W-1:0]  ones_cnt
);

    import stoch_pkg::*;

    localparam int      PC_W   = clog2(NUM_IN + 1);
    localparam coding_e CODING = (BIPOLAR != 0) ? stoch_pkg::BIPOLAR : UNIPOLAR;

    logic [PC_W-1:0]         cnt;
    logic [PC_W-1:0]         act;
    logic [NUM_IN-1:0]       live;

    logic signed [ERR_W-1:0] err_q, err_d;
    logic                    sat_q;
    logic [CNT_W-1:0]        ones_q, ones_d;
    logic                    out_v;
    logic                    clamp_hit;

    int off;
    int delta;
    int raw;
    int sum;

    assign live = in & mask;

    stoch_popcnt #(.W(NUM_IN)) u_pc_in (
        .vec_i (live),
        .cnt_o (cnt)
    );

    stoch_popcnt #(.W(NUM_IN)) u_pc_mask (
        .vec_i (mask),
        .cnt_o (act)
    );

    // Doubled units keep the bipolar half-offset (act-1)/2 integral.
    always_comb begin
        out_v     = en & (int'(err_q) > 0);
        off       = (CODING == stoch_pkg::BIPOLAR) ? (int'(act) - 1) : 0;
        delta     = 2 * int'(cnt) - off - 2 * int'(out_v);
        raw       = int'(err_q) + delta;
        sum       = sat_add(int'(err_q), delta, ERR_W);
        clamp_hit = (sum != raw);
        err_d     = ERR_W'(sum);
        ones_d    = ones_q + CNT_W'(out_v);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q  <= '0;
            sat_q  <= 1'b0;
            ones_q <= '0;
        end else if (clr) begin
            err_q  <= '0;
            sat_q  <= 1'b0;
            ones_q <= '0;
        end else if (en) begin
            err_q  <= err_d;
            sat_q  <= sat_q | clamp_hit;
            ones_q <= ones_d;
        end
    end

    assign out      = out_v;
    assign sat      = sat_q;
    assign ones_cnt = ones_q;

endmodule

// File: tb/tb_stoch_nsadd_par.sv
// Directed bench for stoch_nsadd_par: one unipolar and one bipolar instance share stimulus.
module tb_stoch_nsadd_par;

    logic        clk = 1'b0;
    logic        rst, en, clr;
    logic [15:0] mask, in_v;
    logic        out_u, sat_u, out_b, sat_b;
    logic [15:0] ones_u, ones_b;

    int n_tests = 0;
    int n_fail  = 0;
    int exp5 [5] = '{1, 1, 0, 1, 0};

    always #5 clk = ~clk;

    stoch_nsadd_par #(.NUM_IN(16), .BIPOLAR(0), .ERR_W(14), .CNT_W(16)) dut_u (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .clr      (clr),
        .mask     (mask),
        .in       (in_v),
        .out      (out_u),
        .sat      (sat_u),
        .ones_cnt (ones_u)
    );

    stoch_nsadd_par #(.NUM_IN(16), .BIPOLAR(1), .ERR_W(14), .CNT_W(16)) dut_b (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .clr      (clr),
        .mask     (mask),
        .in       (in_v),
        .out      (out_b),
        .sat      (sat_b),
        .ones_cnt (ones_b)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        en  = 1'b0;
        clr = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst  = 1'b1;
        en   = 1'b0;
        clr  = 1'b0;
        mask = 16'hFFFF;
        in_v = 16'h0000;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("reset_out_u", int'(out_u), 0);
        chk("reset_sat_u", int'(sat_u), 0);
        chk("reset_ones_u", int'(ones_u), 0);
        chk("reset_out_b", int'(out_b), 0);
        chk("reset_sat_b", int'(sat_b), 0);
        chk("reset_ones_b", int'(ones_b), 0);

        // Unipolar, one live input at 1: out 0,1,1,... with err held at 2.
        en   = 1'b1;
        mask = 16'hFFFF;
        in_v = 16'h0001;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("t1_out", int'(out_u), (k == 0) ? 0 : 1);
            tick();
        end
        chk("t1_err", int'(dut_u.err_q), 2);
        chk("t1_ones", int'(ones_u), 5);

        // Unipolar, in[0] toggling: out 0,1,0,1 and half the cycles emit.
        do_reset();
        en = 1'b1;
        for (int k = 0; k < 100; k++) begin
            in_v = (k % 2 == 0) ? 16'h0001 : 16'h0000;
            #1;
            if (k < 4) chk("t2_out", int'(out_u), k % 2);
            tick();
        end
        chk("t2_ones", int'(ones_u), 50);

        // Bipolar, all-ones/all-zeros alternation encodes value 0.
        do_reset();
        en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            in_v = (k % 2 == 0) ? 16'hFFFF : 16'h0000;
            #1;
            chk("t3_out", int'(out_b), k % 2);
            tick();
            chk("t3_err", int'(dut_b.err_q), (k % 2 == 0) ? 17 : 0);
        end

        // Bipolar, constant zeros: err falls 15 per cycle, clamps at -8192.
        do_reset();
        en   = 1'b1;
        in_v = 16'h0000;
        repeat (546) tick();
        chk("t4_err_546", int'(dut_b.err_q), -8190);
        chk("t4_sat_546", int'(sat_b), 0);
        chk("t4_out", int'(out_b), 0);
        tick();
        chk("t4_err_547", int'(dut_b.err_q), -8192);
        chk("t4_sat_547", int'(sat_b), 1);
        tick();
        chk("t4_err_hold", int'(dut_b.err_q), -8192);
        chk("t4_sat_sticky", int'(sat_b), 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("t4_clr_err", int'(dut_b.err_q), 0);
        chk("t4_clr_sat", int'(sat_b), 0);

        // Bipolar single-channel mask then empty mask.
        do_reset();
        en   = 1'b1;
        mask = 16'h0001;
        in_v = 16'h0001;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t5_out_m1", int'(out_b), (k == 0) ? 0 : 1);
            tick();
        end
        mask = 16'h0000;
        in_v = 16'h0000;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("t5_out_m0", int'(out_b), exp5[k]);
            tick();
        end

        // Stall, clear and mid-frame reset on the unipolar instance.
        do_reset();
        en   = 1'b1;
        mask = 16'hFFFF;
        in_v = 16'h0001;
        repeat (5) tick();
        chk("t6_ones_pre", int'(ones_u), 4);
        chk("t6_err_pre", int'(dut_u.err_q), 2);
        en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("t6_stall_out", int'(out_u), 0);
            tick();
        end
        chk("t6_stall_ones", int'(ones_u), 4);
        chk("t6_stall_err", int'(dut_u.err_q), 2);
        en = 1'b1;
        #1;
        chk("t6_resume_out", int'(out_u), 1);
        tick();
        chk("t6_resume_ones", int'(ones_u), 5);
        clr  = 1'b1;
        in_v = 16'hFFFF;
        tick();
        clr  = 1'b0;
        in_v = 16'h0000;
        chk("t6_clr_err", int'(dut_u.err_q), 0);
        chk("t6_clr_ones", int'(ones_u), 0);
        chk("t6_clr_out", int'(out_u), 0);
        tick();
        chk("t6_clr_err_next", int'(dut_u.err_q), 0);
        in_v = 16'hFFFF;
        tick();
        tick();
        chk("t6_pre_rst_ones", int'(ones_u), 1);
        rst = 1'b1;
        tick();
        rst  = 1'b0;
        in_v = 16'h0000;
        chk("t6_rst_out", int'(out_u), 0);
        chk("t6_rst_sat", int'(sat_u), 0);
        chk("t6_rst_ones", int'(ones_u), 0);
        chk("t6_rst_err", int'(dut_u.err_q), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
